// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing generator: free-running h/v counters, coordinate
// output to the pixel source, and sync/blank delayed to meet the returned colour.
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int PIXEL_LAT = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] rgb_r,
    input  logic [7:0] rgb_g,
    input  logic [7:0] rgb_b,
    output logic [9:0] drawx,
    output logic [9:0] drawy,
    output logic       in_visible,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_END    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS_END    = 10'(V_VISIBLE);
    localparam logic [9:0] H_SYNC_START = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] H_SYNC_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] V_SYNC_START = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] V_SYNC_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

    // Stage word layout {fs, vis, vs, hs}; idle is syncs high, blanked, no frame start.
    localparam logic [3:0] STAGE_IDLE = 4'b0011;

    logic [9:0] r_h_cnt;
    logic [9:0] r_v_cnt;
    logic [3:0] r_pipe [0:PIXEL_LAT];
    logic [7:0] r_red;
    logic [7:0] r_grn;
    logic [7:0] r_blu;

    logic       w_hs0;
    logic       w_vs0;
    logic       w_vis0;
    logic       w_fs0;
    logic [3:0] w_stage0;
    logic       w_vis_dly;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == H_LAST) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == V_LAST) ? 10'd0 : r_v_cnt + 10'd1;
        end else begin
            r_h_cnt <= r_h_cnt + 10'd1;
        end
    end

    assign w_hs0    = !((r_h_cnt >= H_SYNC_START) && (r_h_cnt < H_SYNC_END));
    assign w_vs0    = !((r_v_cnt >= V_SYNC_START) && (r_v_cnt < V_SYNC_END));
    assign w_vis0   = (r_h_cnt < H_VIS_END) && (r_v_cnt < V_VIS_END);
    assign w_fs0    = (r_h_cnt == 10'd0) && (r_v_cnt == 10'd0);
    assign w_stage0 = {w_fs0, w_vis0, w_vs0, w_hs0};

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int k = 0; k <= PIXEL_LAT; k++) begin
                r_pipe[k] <= STAGE_IDLE;
            end
        end else begin
            r_pipe[0] <= w_stage0;
            for (int k = 1; k <= PIXEL_LAT; k++) begin
                r_pipe[k] <= r_pipe[k-1];
            end
        end
    end

    // Visibility of the coordinate whose colour is on rgb_* this cycle.
    generate
        if (PIXEL_LAT == 0) begin : g_vis_comb
            assign w_vis_dly = w_vis0;
        end else begin : g_vis_pipe
            assign w_vis_dly = r_pipe[PIXEL_LAT-1][2];
        end
    endgenerate

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_red <= '0;
            r_grn <= '0;
            r_blu <= '0;
        end else begin
            r_red <= w_vis_dly ? rgb_r : 8'd0;
            r_grn <= w_vis_dly ? rgb_g : 8'd0;
            r_blu <= w_vis_dly ? rgb_b : 8'd0;
        end
    end

    assign drawx       = r_h_cnt;
    assign drawy       = r_v_cnt;
    assign in_visible  = w_vis0;
    assign VGA_HS      = r_pipe[PIXEL_LAT][0];
    assign VGA_VS      = r_pipe[PIXEL_LAT][1];
    assign VGA_BLANK_N = r_pipe[PIXEL_LAT][2];
    assign frame_start = r_pipe[PIXEL_LAT][3];
    assign VGA_SYNC_N  = 1'b0;
    assign VGA_R       = r_red;
    assign VGA_G       = r_grn;
    assign VGA_B       = r_blu;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance (PIXEL_LAT=2) and a shrunken
// instance (PIXEL_LAT=0) that wraps whole frames quickly, both checked every cycle.
module tb_vga_timing_gen;

    localparam int A_HV = 640, A_HFP = 16, A_HSW = 96, A_HBP = 48;
    localparam int A_VV = 480, A_VFP = 10, A_VSW = 2,  A_VBP = 33, A_LAT = 2;
    localparam int B_HV = 16,  B_HFP = 4,  B_HSW = 6,  B_HBP = 6;
    localparam int B_VV = 12,  B_VFP = 3,  B_VSW = 2,  B_VBP = 4,  B_LAT = 0;

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        vis;
        logic        hs;
        logic        vs;
        logic        blank_n;
        logic        fs;
        logic [23:0] rgb;
    } exp_t;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    logic [7:0] a_rgb_r, a_rgb_g, a_rgb_b, b_rgb_r, b_rgb_g, b_rgb_b;
    logic [9:0] a_drawx, a_drawy, b_drawx, b_drawy;
    logic       a_vis, a_hs, a_vs, a_blank_n, a_sync_n, a_fs;
    logic       b_vis, b_hs, b_vs, b_blank_n, b_sync_n, b_fs;
    logic [7:0] a_r, a_g, a_b, b_r, b_g, b_b;

    vga_timing_gen #(
        .H_VISIBLE(A_HV), .H_FP(A_HFP), .H_SYNC(A_HSW), .H_BP(A_HBP),
        .V_VISIBLE(A_VV), .V_FP(A_VFP), .V_SYNC(A_VSW), .V_BP(A_VBP),
        .PIXEL_LAT(A_LAT)
    ) dut_a (
        .Clk(Clk), .Reset(Reset),
        .rgb_r(a_rgb_r), .rgb_g(a_rgb_g), .rgb_b(a_rgb_b),
        .drawx(a_drawx), .drawy(a_drawy), .in_visible(a_vis),
        .VGA_HS(a_hs), .VGA_VS(a_vs), .VGA_BLANK_N(a_blank_n), .VGA_SYNC_N(a_sync_n),
        .VGA_R(a_r), .VGA_G(a_g), .VGA_B(a_b), .frame_start(a_fs)
    );

    vga_timing_gen #(
        .H_VISIBLE(B_HV), .H_FP(B_HFP), .H_SYNC(B_HSW), .H_BP(B_HBP),
        .V_VISIBLE(B_VV), .V_FP(B_VFP), .V_SYNC(B_VSW), .V_BP(B_VBP),
        .PIXEL_LAT(B_LAT)
    ) dut_b (
        .Clk(Clk), .Reset(Reset),
        .rgb_r(b_rgb_r), .rgb_g(b_rgb_g), .rgb_b(b_rgb_b),
        .drawx(b_drawx), .drawy(b_drawy), .in_visible(b_vis),
        .VGA_HS(b_hs), .VGA_VS(b_vs), .VGA_BLANK_N(b_blank_n), .VGA_SYNC_N(b_sync_n),
        .VGA_R(b_r), .VGA_G(b_g), .VGA_B(b_b), .frame_start(b_fs)
    );

    int n = 0;          // cycles since the last edge that sampled Reset high
    int mode = 0;       // 0: colour encodes coordinate, 1: constant white
    bit check_en = 1'b0;
    int checks = 0;
    int passes = 0;
    int fails = 0;

    function automatic logic [23:0] src(input int x, input int y, input int md);
        logic [7:0] xb;
        logic [7:0] yb;
        xb = 8'(x);
        yb = 8'(y);
        if (md == 1) return 24'hFFFFFF;
        return {xb, yb, xb ^ yb};
    endfunction

    // Output expectations from raster arithmetic: counter position is n, pins
    // show the position from lat+1 cycles earlier, nothing before that.
    function automatic exp_t model(input int cyc, input int hv, input int hfp, input int hsw,
                                   input int hbp, input int vv, input int vfp, input int vsw,
                                   input int vbp, input int lat, input int md);
        exp_t e;
        int ht, vt, m, mx, my;
        ht = hv + hfp + hsw + hbp;
        vt = vv + vfp + vsw + vbp;
        e.x   = 10'(cyc % ht);
        e.y   = 10'((cyc / ht) % vt);
        e.vis = ((cyc % ht) < hv) && (((cyc / ht) % vt) < vv);
        if (cyc < lat + 1) begin
            e.hs = 1'b1; e.vs = 1'b1; e.blank_n = 1'b0; e.fs = 1'b0; e.rgb = '0;
        end else begin
            m  = cyc - lat - 1;
            mx = m % ht;
            my = (m / ht) % vt;
            e.hs      = !((mx >= hv + hfp) && (mx < hv + hfp + hsw));
            e.vs      = !((my >= vv + vfp) && (my < vv + vfp + vsw));
            e.blank_n = (mx < hv) && (my < vv);
            e.fs      = (mx == 0) && (my == 0);
            e.rgb     = e.blank_n ? src(mx, my, md) : 24'd0;
        end
        return e;
    endfunction

    function automatic exp_t model_a(input int cyc);
        return model(cyc, A_HV, A_HFP, A_HSW, A_HBP, A_VV, A_VFP, A_VSW, A_VBP, A_LAT, mode);
    endfunction

    function automatic exp_t model_b(input int cyc);
        return model(cyc, B_HV, B_HFP, B_HSW, B_HBP, B_VV, B_VFP, B_VSW, B_VBP, B_LAT, mode);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            fails++;
            if (fails <= 30)
                $display("FAIL %s n=%0d actual=%0h expected=%0h", name, n, act, exp);
        end
    endtask

    // Source models: colour for the coordinate of cycle t appears at t+lat.
    task automatic drive_src();
        exp_t ea;
        exp_t eb;
        if (n >= A_LAT) begin
            ea = model_a(n - A_LAT);
            {a_rgb_r, a_rgb_g, a_rgb_b} = src(int'(ea.x), int'(ea.y), mode);
        end else begin
            {a_rgb_r, a_rgb_g, a_rgb_b} = 24'h5A5A5A;
        end
        eb = model_b(n - B_LAT);
        {b_rgb_r, b_rgb_g, b_rgb_b} = src(int'(eb.x), int'(eb.y), mode);
    endtask

    task automatic tick(input logic rst_next);
        @(posedge Clk);
        #1;
        if (Reset) n = 0;
        else       n = n + 1;
        check_en = 1'b1;
        Reset = rst_next;
        drive_src();
        #1;
    endtask

    always @(negedge Clk) begin
        exp_t ea;
        exp_t eb;
        if (check_en) begin
            ea = model_a(n);
            eb = model_b(n);
            check("a_coord", {11'd0, a_drawx, a_drawy, a_vis}, {11'd0, ea.x, ea.y, ea.vis});
            check("a_ctrl", {27'd0, a_hs, a_vs, a_blank_n, a_sync_n, a_fs},
                  {27'd0, ea.hs, ea.vs, ea.blank_n, 1'b0, ea.fs});
            check("a_rgb", {8'd0, a_r, a_g, a_b}, {8'd0, ea.rgb});
            check("b_coord", {11'd0, b_drawx, b_drawy, b_vis}, {11'd0, eb.x, eb.y, eb.vis});
            check("b_ctrl", {27'd0, b_hs, b_vs, b_blank_n, b_sync_n, b_fs},
                  {27'd0, eb.hs, eb.vs, eb.blank_n, 1'b0, eb.fs});
            check("b_rgb", {8'd0, b_r, b_g, b_b}, {8'd0, eb.rgb});
        end
    end

    initial begin
        int hs_first_low;
        int hs_low_cnt;
        int blank_cnt;
        int b_last_fs;
        int b_vs_low;

        {a_rgb_r, a_rgb_g, a_rgb_b} = '0;
        {b_rgb_r, b_rgb_g, b_rgb_b} = '0;
        hs_first_low = -1;
        hs_low_cnt   = 0;
        blank_cnt    = 0;
        b_last_fs    = -1;
        b_vs_low     = 0;

        // Reset held high: everything parked at reset values.
        for (int i = 0; i < 10; i++) begin
            tick((i == 9) ? 1'b0 : 1'b1);
            check("rst_drawxy", {12'd0, a_drawx, a_drawy}, 32'd0);
            check("rst_pins", {24'd0, a_hs, a_vs, a_blank_n, a_fs, 4'd0}, {24'd0, 4'b1100, 4'd0});
            check("rst_rgb", {8'd0, a_r, a_g, a_b}, 32'd0);
        end

        // Free run with coordinate-encoded colour.
        while (n < 5900) begin
            tick(1'b0);
            if (n <= 802) begin
                if (!a_hs) begin
                    if (hs_first_low < 0) hs_first_low = n;
                    hs_low_cnt++;
                end
                if (a_blank_n) blank_cnt++;
            end
            if (n == 803) begin
                check("hs_first_low", hs_first_low, 659);
                check("hs_low_len", hs_low_cnt, 96);
                check("blank_len", blank_cnt, 640);
            end
            if (n == 7 * 800 + 5 + 3) begin
                check("pix57_r", {24'd0, a_r}, 32'd5);
                check("pix57_g", {24'd0, a_g}, 32'd7);
                check("pix57_blank", {31'd0, a_blank_n}, 32'd1);
            end
            if (b_fs) begin
                if (b_last_fs >= 0) check("b_fs_spacing", n - b_last_fs, 672);
                b_last_fs = n;
            end
            if (n >= 1 && n <= 672 && !b_vs) b_vs_low++;
            if (n == 673) check("b_vs_low_len", b_vs_low, 64);
        end

        // One-cycle reset mid-line at (300,7), then switch the source to white.
        check("pre_rst_xy", {12'd0, a_drawx, a_drawy}, {12'd0, 10'd300, 10'd7});
        tick(1'b1);
        tick(1'b0);
        mode = 1;
        drive_src();
        check("mid_rst_xy", {12'd0, a_drawx, a_drawy}, 32'd0);
        check("mid_rst_pins", {30'd0, a_hs, a_blank_n}, {30'd0, 2'b10});
        while (n < 3000) begin
            tick(1'b0);
            if (n == 2) check("fs_not_yet", {31'd0, a_fs}, 32'd0);
            if (n == 3) check("fs_after_rel", {31'd0, a_fs}, 32'd1);
            if (n == 4) check("fs_one_cycle", {31'd0, a_fs}, 32'd0);
            if (n == 700) check("white_h700", {8'd0, a_r, a_g, a_b}, 32'd0);
            if (n == 10) check("white_vis", {8'd0, a_r, a_g, a_b}, 32'h00FFFFFF);
        end

        check_en = 1'b0;
        @(posedge Clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
